rr_arbi_merge: RTL
==================

# rr_arbi_merge

N-way arbitrated merge with round-robin fairness and optional packet locking, the clocked successor to the team's two-input random-choice merge. Accepts flits from N valid/ready input channels, grants one per cycle, and forwards it through a 2-entry output buffer tagged with its source index. It sits at router output ports and the PE-to-NoC injection points, where multi-flit packets must not interleave.

## Interface
Parameters:
- WIDTH, 32, flit data width
- N, 4, number of input channels (2..16)
- LOCK_PKT, 1, 1 = hold grant from first flit until in_last flit; 0 = re-arbitrate every flit
- IDXW, $clog2(N), source-index width (derived, not overridden)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  N  per-channel flit valid
- in_ready  out  N  per-channel accept; at most one bit high
- in_data  in  N×WIDTH  per-channel flit data
- in_last  in  N  per-channel end-of-packet flag
- out_valid  out  1  output flit valid
- out_ready  in  1  downstream accept
- out_data  out  WIDTH  output flit data
- out_last  out  1  end-of-packet flag of output flit
- out_src  out  IDXW  index of input channel the flit came from

## Operation
- Transfer on input i: in_valid[i] && in_ready[i] at a rising edge. Output transfer: out_valid && out_ready.
- State: rr_ptr (IDXW), lock (1), lock_idx (IDXW), 2-entry output FIFO (count 0..2).
- Arbitration (combinational): if lock, candidate = lock_idx; else candidate = first i with in_valid[i], searching rr_ptr, rr_ptr+1, … mod N.
- in_ready[candidate] = 1 iff candidate has in_valid and FIFO count < 2 (registered count only; no path from out_ready to in_ready). All other in_ready bits 0.
- On input transfer from w: push {in_data[w], in_last[w], w}.
  - LOCK_PKT=1: if in_last[w]=0, lock←1, lock_idx←w; if in_last[w]=1, lock←0, rr_ptr←(w+1) mod N.
  - LOCK_PKT=0: rr_ptr←(w+1) mod N each transfer; lock stays 0.
- Locked with in_valid[lock_idx]=0: no grant issued; other channels stall (bubble), lock retained.
- No transfer: rr_ptr and lock unchanged.
- FIFO: push and pop in the same cycle are legal at count 1 (count stays 1) and count 2 (pop only, since ready=0). Order preserved.
- Outputs driven from FIFO head register; out_valid = (count != 0).

## Timing
- Reset (async assert, sync-to-clk deassert by system): out_valid=0, out_data=0, out_last=0, out_src=0, in_ready=0, rr_ptr=0, lock=0, count=0. Reset mid-packet discards FIFO contents and lock.
- Latency: flit accepted at edge k is on out_* after edge k (visible in cycle k+1) if FIFO was empty.
- Throughput: 1 flit/cycle sustained with out_ready held high.
- out_* stable while out_valid && !out_ready.
- rr_ptr wrap: winner N-1 → rr_ptr 0.
- Fairness: with all N requesting single-flit packets, each channel granted exactly once per N consecutive transfers.

## Structure
- Package rr_merge_pkg: parameterised flit struct {data, last, src}; function rr_pick(req, ptr) returning first-set index from ptr with wrap.
- Sub-module rr_merge_fifo2: 2-entry register FIFO (push/pop/full/empty/head), async active-low reset, reused elsewhere as the skid stage.
- Top holds arbitration, lock and rr_ptr logic only.

## Test plan
- N=4, WIDTH=8, LOCK_PKT=0, all four valid with single-flit data 0x10+i, out_ready=1 -> out_src sequence 0,1,2,3,0,… one flit per cycle, data matches source.
- LOCK_PKT=1, ch1 sends 3-flit packet 0xA1,0xA2,0xA3(last) while ch2 holds 0xB1(last) -> out order A1,A2,A3,B1; in_ready[2]=0 until after A3 accepted; rr_ptr=2 after A3.
- LOCK_PKT=1, ch0 drops in_valid for 2 cycles mid-packet while ch3 valid -> no ch3 grant during gap; ch0 packet completes contiguous.
- out_ready=0 for 5 cycles with ch2 streaming -> exactly 2 flits buffered, in_ready all 0, out_data holds first flit; release -> no loss/duplication.
- Only ch3 valid, rr_ptr=3, single flit -> granted, rr_ptr wraps to 0.
- rst_n asserted mid-packet with FIFO count=2 -> out_valid=0 immediately; after release, new packet from ch2 granted with lock clear.

Source files
------------

// File: rtl/rr_merge_pkg.sv
// Shared definitions for the round-robin arbitrated merge: size limits and
// the wrap-around first-set picker used by the arbiter.
package rr_merge_pkg;

  localparam int MAX_N    = 16;
  localparam int MAX_IDXW = 4;

  // Returns the first index with req set, searching ptr, ptr+1, ... mod n.
  // When nothing is requested the pointer itself comes back; callers must
  // qualify the result with the request bit.
  function automatic logic [MAX_IDXW-1:0] rr_pick(
    input logic [MAX_N-1:0]    req,
    input logic [MAX_IDXW-1:0] ptr,
    input int                  n
  );
    logic [MAX_IDXW-1:0] pick;
    logic                found;
    int                  idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req[idx[MAX_IDXW-1:0]]) begin
        pick  = idx[MAX_IDXW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_merge_fifo2.sv
// Two-entry register FIFO with a registered head; used as the output buffer
// of the merge and as a generic skid stage.
module rr_merge_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  logic [DW-1:0] slot0;
  logic [DW-1:0] slot1;
  logic [1:0]    count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = slot0;

  // Storage and occupancy update; slot0 is always the oldest entry.
  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two slots are reset because slot0 drives the block outputs
      // directly and must read zero out of reset.
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rr_arbi_merge.sv
// N-way arbitrated merge: round-robin grant with optional packet locking,
// one flit per cycle into a 2-entry output buffer tagged with its source.
module rr_arbi_merge
  import rr_merge_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N        = 4,
  parameter int LOCK_PKT = 1,
  parameter int IDXW     = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          in_valid,
  output logic [N-1:0]          in_ready,
  input  logic [N-1:0][WIDTH-1:0] in_data,
  input  logic [N-1:0]          in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [IDXW-1:0]       out_src
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic [IDXW-1:0]  src;
  } flit_t;

  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] lock_idx;
  logic            lock;
  logic [IDXW-1:0] cand;
  logic [IDXW-1:0] next_ptr;
  logic            grant;
  logic            fifo_full;
  logic            fifo_empty;
  flit_t           push_flit;
  flit_t           head_flit;

  // Choose this cycle's candidate and raise its ready when the buffer has room.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    in_ready  = '0;
    cand      = lock ? lock_idx
                     : IDXW'(rr_pick(MAX_N'(in_valid), MAX_IDXW'(rr_ptr), N));
    // Ready uses only the registered fill level, never out_ready.
    grant     = rst_n && in_valid[cand] && !fifo_full;
    if (grant) in_ready[cand] = 1'b1;
    push_flit = '{data: in_data[cand], last: in_last[cand], src: cand};
    next_ptr  = (cand == IDXW'(N - 1)) ? '0 : cand + 1'b1;
  end

  // Lock and round-robin pointer advance on each accepted flit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (grant) begin
      if (LOCK_PKT != 0 && !in_last[cand]) begin
        lock     <= 1'b1;
        lock_idx <= cand;
      end else begin
        lock   <= 1'b0;
        rr_ptr <= next_ptr;
      end
    end
  end

  rr_merge_fifo2 #(
    .DW($bits(flit_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (grant),
    .push_data(push_flit),
    .pop      (out_valid && out_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_flit)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head_flit.data;
  assign out_last  = head_flit.last;
  assign out_src   = head_flit.src;

endmodule
